ysyx_22050133_ifq: RTL and testbench

YSYX_22050133_IFQ -- requirements
Module: ysyx_22050133_ifq

---
 rtl/ysyx_22050133_ifq.sv | 109 ++++++++++
 tb/tb_ysyx_22050133_ifq.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050133_ifq.sv
// Instruction fetch queue: issues one 64-bit fetch at a time from the fetch PC
// and buffers the selected 32-bit instruction with its PC for the decoder.
module ysyx_22050133_ifq #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          mem_req_valid,
  output logic [31:0]   mem_req_addr,
  input  logic          mem_req_ready,
  input  logic          mem_rsp_valid,
  input  logic [63:0]   mem_rsp_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  output logic [CW-1:0] q_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [31:0]   req_pc;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic        handshake;
  logic        push;
  logic        pop;
  logic        space_now;
  logic        space_after;
  logic [31:0] rsp_inst;
  logic [31:0] redirect_tgt;

  // A redirect wins over any response or pop landing in the same cycle.
  always_comb begin
    handshake    = (state == REQ) && mem_req_ready;
    push         = (state == WAIT) && mem_rsp_valid && !redirect_valid;
    pop          = (count != '0) && out_ready && !redirect_valid;
    rsp_inst     = req_pc[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0];
    redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    space_now    = 32'(count) < 32'(DEPTH);
    space_after  = (32'(count) + 32'(push) - 32'(pop)) < 32'(DEPTH);
  end

  assign mem_req_valid = rst && (state == REQ);
  assign mem_req_addr  = fpc;
  assign out_valid     = rst && (count != '0);
  assign out_pc        = pc_mem[head];
  assign out_inst      = inst_mem[head];
  assign q_count       = rst ? count : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= REQ;
      fpc    <= RESET_PC & 32'hFFFF_FFFC;
      req_pc <= RESET_PC & 32'hFFFF_FFFC;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      fpc   <= redirect_tgt;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // DROP is needed only while a response is still owed by the memory.
      unique case (state)
        WAIT:    state <= mem_rsp_valid ? REQ : DROP;
        REQ:     state <= handshake ? DROP : REQ;
        DROP:    state <= mem_rsp_valid ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
      unique case (state)
        IDLE: if (space_now) state <= REQ;
        REQ: if (handshake) begin
          state  <= WAIT;
          req_pc <= fpc;
          fpc    <= fpc + 32'd4;
        end
        WAIT: if (mem_rsp_valid) state <= space_after ? REQ : IDLE;
        DROP: if (mem_rsp_valid) state <= REQ;
      endcase
    end
  end

  // NOTE: queue storage is not reset; head/tail/count alone decide which
  // entries are meaningful, so clearing the array would only add reset fanout.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= req_pc;
      inst_mem[tail] <= rsp_inst;
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_ifq.sv
// Bench for the fetch queue: a latency-configurable memory responder, an
// in-order program-stream scoreboard, and directed redirect/reset scenarios.
module tb_ysyx_22050133_ifq;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          DEPTH    = 4;
  localparam int          CW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          mem_req_valid;
  logic [31:0]   mem_req_addr;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [63:0]   mem_rsp_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic [CW-1:0] q_count;

  always #5 clk = ~clk;

  ysyx_22050133_ifq #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .q_count        (q_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program image: every word address holds a distinct instruction, except the
  // two words of the boot dword which hold addi/nop encodings.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    if (pc == 32'h8000_0000) return 32'h0000_0093;
    if (pc == 32'h8000_0004) return 32'h0000_0013;
    return {pc[15:0], pc[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  function automatic logic [63:0] dword_at(input logic [31:0] a);
    logic [31:0] base;
    base = {a[31:3], 3'b000};
    return {inst_of(base + 32'd4), inst_of(base)};
  endfunction

  // Scoreboard: the in-order instruction stream the decoder must see.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_next;

  task automatic refill();
    exp_t e;
    while (exp_q.size() < 32) begin
      e.pc   = exp_next;
      e.inst = inst_of(exp_next);
      exp_q.push_back(e);
      exp_next = exp_next + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    exp_next = pc & 32'hFFFF_FFFC;
    refill();
  endtask

  // Memory responder with configurable latency and ready behaviour.
  typedef struct {
    logic [31:0] addr;
    int          cnt;
  } pend_t;

  pend_t       pend_q[$];
  int          lat_min    = 1;
  int          lat_max    = 1;
  bit          rand_ready = 1'b0;
  int          hs_cnt     = 0;
  logic [31:0] last_addr  = '0;

  initial begin
    logic        hs;
    logic        prev_stall;
    logic [31:0] a;
    logic [31:0] prev_addr;
    pend_t       p;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    prev_stall    = 1'b0;
    prev_addr     = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && rst) begin
        check("req_hold_valid", 64'(mem_req_valid), 64'(1));
        check("req_hold_addr", 64'(mem_req_addr), 64'(prev_addr));
      end
      hs         = rst && mem_req_valid && mem_req_ready;
      prev_stall = rst && mem_req_valid && !mem_req_ready && !redirect_valid;
      prev_addr  = mem_req_addr;
      a          = mem_req_addr;
      if (hs) begin
        check("one_outstanding", 64'(pend_q.size()), 64'(0));
        hs_cnt++;
        last_addr = a;
      end
      @(posedge clk);
      #1;
      if (hs) begin
        p.addr = a;
        p.cnt  = int'($urandom_range(lat_max, lat_min));
        pend_q.push_back(p);
      end
      foreach (pend_q[i]) pend_q[i].cnt--;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = {$urandom, $urandom};
      if (pend_q.size() > 0 && pend_q[0].cnt <= 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = dword_at(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
      mem_req_ready = rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
  end

  // Monitor: every consumed head entry must be the next expected instruction.
  int pop_cnt = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("out_valid_vs_count", 64'(out_valid), 64'(q_count != '0));
        check("count_bound", 64'(32'(q_count) <= DEPTH), 64'(1));
        if (out_valid && out_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 64'(0), 64'(1));
          end else begin
            e = exp_q.pop_front();
            check("out_pc", 64'(out_pc), 64'(e.pc));
            check("out_inst", 64'(out_inst), 64'(e.inst));
            pop_cnt++;
            refill();
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    restart(RESET_PC);
    steps(6);
    @(negedge clk);
    check("rst_req_valid", 64'(mem_req_valid), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_q_count", 64'(q_count), 64'(0));
    step();
    rst    = 1'b1;
    hs_cnt = 0;
  endtask

  initial begin
    int p0;
    int b;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    // Boot fetch: both halves of the first dword in order.
    lat_min = 1; lat_max = 1; rand_ready = 1'b0;
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    check("A_first_req_valid", 64'(mem_req_valid), 64'(1));
    check("A_first_req_addr", 64'(mem_req_addr), 64'(RESET_PC));
    p0 = pop_cnt;
    steps(12);
    check("A_pops", 64'(pop_cnt - p0 >= 2), 64'(1));

    // Fill to DEPTH with the consumer stalled, then free one slot.
    do_reset();
    steps(20);
    @(negedge clk);
    check("B_q_full", 64'(q_count), 64'(DEPTH));
    check("B_no_req", 64'(mem_req_valid), 64'(0));
    check("B_out_valid", 64'(out_valid), 64'(1));
    check("B_hs_cnt", 64'(hs_cnt), 64'(4));
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    steps(6);
    @(negedge clk);
    check("B_hs_cnt_after_pop", 64'(hs_cnt), 64'(5));
    check("B_refetch_addr", 64'(last_addr), 64'(32'h8000_0010));
    check("B_q_refull", 64'(q_count), 64'(DEPTH));
    check("B_idle_again", 64'(mem_req_valid), 64'(0));

    // Redirect while waiting; the stale beat lands two cycles later.
    lat_min = 3; lat_max = 3;
    do_reset();
    b = 0;
    while (hs_cnt < 1 && b < 20) begin
      step();
      b++;
    end
    check("C_hs_seen", 64'(hs_cnt >= 1), 64'(1));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1006;
    restart(32'h8000_1006);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("C_drop_no_req", 64'(mem_req_valid), 64'(0));
    check("C_drop_q_empty", 64'(q_count), 64'(0));
    step();
    @(negedge clk);
    check("C_stale_beat", 64'(mem_rsp_valid), 64'(1));
    check("C_drop_no_req2", 64'(mem_req_valid), 64'(0));
    step();
    @(negedge clk);
    check("C_req_valid", 64'(mem_req_valid), 64'(1));
    check("C_req_addr", 64'(mem_req_addr), 64'(32'h8000_1004));
    check("C_q_empty", 64'(q_count), 64'(0));
    out_ready = 1'b1;
    p0 = pop_cnt;
    steps(20);
    check("C_pops", 64'(pop_cnt - p0 >= 2), 64'(1));

    // Redirect coinciding with a request handshake and a pop.
    lat_min = 1; lat_max = 1;
    do_reset();
    steps(4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    out_ready      = 1'b1;
    restart(32'h8000_2000);
    @(negedge clk);
    check("D_in_req", 64'(mem_req_valid), 64'(1));
    check("D_q_two", 64'(q_count), 64'(2));
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    @(negedge clk);
    check("D_flushed", 64'(q_count), 64'(0));
    check("D_drop_no_req", 64'(mem_req_valid), 64'(0));
    check("D_stale_beat", 64'(mem_rsp_valid), 64'(1));
    step();
    @(negedge clk);
    check("D_req_addr", 64'(mem_req_addr), 64'(32'h8000_2000));
    check("D_req_valid", 64'(mem_req_valid), 64'(1));
    check("D_q_empty", 64'(q_count), 64'(0));
    steps(2);
    @(negedge clk);
    check("D_q_one", 64'(q_count), 64'(1));
    check("D_head_pc", 64'(out_pc), 64'(32'h8000_2000));
    check("D_head_inst", 64'(out_inst), 64'(inst_of(32'h8000_2000)));

    // Reset in WAIT with three entries queued; the stale beat falls in reset.
    lat_min = 3; lat_max = 3;
    do_reset();
    b = 0;
    while (b < 80) begin
      step();
      b++;
      @(negedge clk);
      if (q_count == 3 && pend_q.size() > 0 && !mem_req_valid) break;
    end
    check("E_reached_wait_q3", 64'(b < 80), 64'(1));
    step();
    rst = 1'b0;
    restart(RESET_PC);
    @(negedge clk);
    check("E_rst_q_count", 64'(q_count), 64'(0));
    check("E_rst_out_valid", 64'(out_valid), 64'(0));
    check("E_rst_req_valid", 64'(mem_req_valid), 64'(0));
    steps(2);
    rst = 1'b1;
    @(negedge clk);
    check("E_req_valid", 64'(mem_req_valid), 64'(1));
    check("E_req_addr", 64'(mem_req_addr), 64'(RESET_PC));
    check("E_q_empty", 64'(q_count), 64'(0));
    out_ready = 1'b1;
    p0 = pop_cnt;
    steps(20);
    check("E_pops", 64'(pop_cnt - p0 >= 2), 64'(1));

    // Random traffic: stalls on both sides, variable latency, random redirects.
    rand_ready = 1'b1; lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 4) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
        restart(redirect_pc);
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    p0 = pop_cnt;
    steps(40);
    check("R_drain_pops", 64'(pop_cnt - p0 > 0), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
